// File: rtl/seg_scan4_pkg.sv
// seg_scan4 shared constants: active-low segment patterns and anode codes.
// Segment bit order is {g,f,e,d,c,b,a}.
package seg_scan4_pkg;

  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  localparam logic [3:0] AN_OFF   = 4'b1111;

  function automatic logic [3:0] an_sel(input logic [1:0] idx);
    an_sel = ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/seg_scan4_bcd7seg.sv
// bcd7seg: BCD digit to active-low 7-segment pattern.
// Codes 10..15 show a dash so bad counter values are visible.
module bcd7seg
  import seg_scan4_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan4.sv
// seg_scan4: frame-latched 4-digit multiplexed 7-segment driver.
// Digits are captured once per frame so the display never tears.
module seg_scan4
  import seg_scan4_pkg::*;
#(
  parameter int SCAN_DIV = 12500
) (
  input  logic       clk,
  input  logic       cr,
  input  logic [3:0] d3,
  input  logic [3:0] d2,
  input  logic [3:0] d1,
  input  logic [3:0] d0,
  input  logic [3:0] dp_en,
  input  logic       lz_en,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       fr
);

  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);

  logic [DW-1:0]   div_q, div_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0][3:0] sh_q, sh_d;
  logic [3:0]      dpm_q, dpm_d;
  logic            lz_q, lz_d;
  logic            fr_q, fr_d;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;

  logic            tick;
  logic            cap;
  logic [3:0]      cur;
  logic [6:0]      dec;
  logic [3:0]      blank;

  assign tick = (div_q == DIV_MAX);
  assign cap  = tick && (idx_q == 2'd3);
  assign cur  = sh_q[idx_q];

  bcd7seg u_dec (
    .bcd_i (cur),
    .seg_o (dec)
  );

  // A digit blanks only if it and every digit left of it is zero.
  always_comb begin
    blank    = 4'b0000;
    blank[3] = lz_q && (sh_q[3] == 4'd0);
    blank[2] = blank[3] && (sh_q[2] == 4'd0);
    blank[1] = blank[2] && (sh_q[1] == 4'd0);
  end

  always_comb begin
    div_d = tick ? '0 : div_q + 1'b1;
    idx_d = tick ? idx_q + 2'd1 : idx_q;
    sh_d  = cap ? {d3, d2, d1, d0} : sh_q;
    dpm_d = cap ? dp_en : dpm_q;
    lz_d  = cap ? lz_en : lz_q;
    fr_d  = cap;
    an_d  = an_sel(idx_q);
    seg_d = blank[idx_q] ? SEG_OFF : dec;
    dp_d  = ~dpm_q[idx_q];
  end

  always_ff @(posedge clk) begin
    if (cr) begin
      div_q <= '0;
      idx_q <= 2'd0;
      sh_q  <= '0;
      dpm_q <= 4'b0000;
      lz_q  <= 1'b0;
      fr_q  <= 1'b0;
      an_q  <= AN_OFF;
      seg_q <= SEG_OFF;
      dp_q  <= 1'b1;
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
      sh_q  <= sh_d;
      dpm_q <= dpm_d;
      lz_q  <= lz_d;
      fr_q  <= fr_d;
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;
  assign fr  = fr_q;

endmodule

// File: tb/tb_seg_scan4.sv
// tb_seg_scan4: directed checks of scan, capture, blanking and reset.
// Runs with SCAN_DIV=4 so one frame is 16 cycles.
module tb_seg_scan4;

  logic       clk = 1'b0;
  logic       cr;
  logic [3:0] d3, d2, d1, d0;
  logic [3:0] dp_en;
  logic       lz_en;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       fr;

  int errs = 0;
  int n_chk = 0;

  seg_scan4 #(.SCAN_DIV(4)) dut (
    .clk   (clk),
    .cr    (cr),
    .d3    (d3),
    .d2    (d2),
    .d1    (d1),
    .d0    (d0),
    .dp_en (dp_en),
    .lz_en (lz_en),
    .an    (an),
    .seg   (seg),
    .dp    (dp),
    .fr    (fr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_fr();
    int n;
    n = 0;
    step(1);
    while (!fr && n < 40) begin
      step(1);
      n++;
    end
    if (!fr) check("fr_timeout", 32'(fr), 1);
  endtask

  // Call in the first cycle with reset state visible and cr low.
  task automatic startup(input string tag);
    int cyc;
    check({tag, "_an1"}, 32'(an), 32'hF);
    check({tag, "_seg1"}, 32'(seg), 32'h7F);
    check({tag, "_dp1"}, 32'(dp), 1);
    check({tag, "_fr1"}, 32'(fr), 0);
    for (int c = 2; c <= 5; c++) begin
      step(1);
      check($sformatf("%s_an%0d", tag, c), 32'(an), 32'hE);
      check($sformatf("%s_seg%0d", tag, c), 32'(seg), 32'h40);
    end
    step(1);
    check({tag, "_an6"}, 32'(an), 32'hD);
    cyc = 6;
    while (!fr && cyc < 60) begin
      step(1);
      cyc++;
    end
    check({tag, "_fr_lat"}, cyc - 1, 16);
  endtask

  // Call in the fr cycle; checks mid-slot of each digit of the frame.
  task automatic frame(input string tag,
                       input logic [6:0] s0, input logic [6:0] s1,
                       input logic [6:0] s2, input logic [6:0] s3,
                       input logic [3:0] dpx);
    logic [6:0] sx [4];
    logic [3:0] anx;
    sx[0] = s0; sx[1] = s1; sx[2] = s2; sx[3] = s3;
    step(2);
    for (int s = 0; s < 4; s++) begin
      if (s > 0) step(4);
      anx = ~(4'b0001 << s);
      check($sformatf("%s_an%0d", tag, s), 32'(an), 32'(anx));
      check($sformatf("%s_seg%0d", tag, s), 32'(seg), 32'(sx[s]));
      check($sformatf("%s_dp%0d", tag, s), 32'(dp), 32'(dpx[s]));
    end
  endtask

  initial begin
    cr = 1'b1;
    {d3, d2, d1, d0} = {4'd1, 4'd2, 4'd5, 4'd9};
    dp_en = 4'b0000;
    lz_en = 1'b0;
    step(3);
    cr = 1'b0;
    startup("rst");

    frame("rot", 7'h10, 7'h12, 7'h24, 7'h79, 4'b1111);

    wait_fr();
    step(2);
    check("tear_seg0", 32'(seg), 32'h10);
    step(4);
    check("tear_seg1", 32'(seg), 32'h12);
    d0 = 4'd3;
    d3 = 4'd7;
    step(4);
    check("tear_seg2", 32'(seg), 32'h24);
    step(4);
    check("tear_an3", 32'(an), 32'h7);
    check("tear_seg3", 32'(seg), 32'h79);
    wait_fr();
    frame("upd", 7'h30, 7'h12, 7'h24, 7'h78, 4'b1111);

    {d3, d2, d1, d0} = {4'd0, 4'd0, 4'd4, 4'd0};
    lz_en = 1'b1;
    wait_fr();
    frame("lz", 7'h40, 7'h19, 7'h7F, 7'h7F, 4'b1111);

    {d3, d2, d1, d0} = {4'd0, 4'd0, 4'hC, 4'd5};
    dp_en = 4'b0010;
    wait_fr();
    frame("dpinv", 7'h12, 7'h3F, 7'h7F, 7'h7F, 4'b1101);

    wait_fr();
    step(9);
    check("mid_an_idx2", 32'(an), 32'hB);
    cr = 1'b1;
    step(1);
    cr = 1'b0;
    startup("mid");

    $display("Result: errors=%0d of %0d checks", errs, n_chk);
    $finish;
  end

endmodule
